// File: rtl/z80_mmio_uart.sv
`default_nettype none
// ============================================================================
// Module   : z80_mmio_uart
// Purpose  : Memory-mapped UART responder for the Z80 bus. A write to
//            DATA_ADDR loads the TX holding register. A read of DATA_ADDR
//            pops the RX FIFO. STATUS_ADDR returns
//            {3'b0, frm_err, tx_drop, rx_ovr, rx_avail, tx_full}.
// Ports    : clk, reset (async, active-high)
//            addr[15:0], mreq_n, rd_n, wr_n, din[7:0]  - CPU bus inputs
//            dout[7:0], sel                             - read-data mux feed
//            rx (async serial in), tx (serial out)
// Revision : 1.0 - initial release
// ============================================================================
module z80_mmio_uart #(
  parameter int          CLK_HZ      = 12000000,
  parameter int          BAUD        = 9600,
  parameter logic [15:0] DATA_ADDR   = 16'hFFFF,
  parameter logic [15:0] STATUS_ADDR = 16'hFFFD,
  parameter int          RX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        sel,
  input  logic        rx,
  output logic        tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(RX_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  // The falling edge is seen two cycles late through the synchroniser and
  // START begins one cycle after that, so the mid-bit sample lands at DIV/2-2.
  localparam logic [CW-1:0] MID_LAST  = CW'(DIV / 2 - 2);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;  // framing error: wait for idle line

  // ---------------------------------------------------------------- bus decode
  logic hit_data, hit_stat;
  logic rd_data_acc, rd_stat_acc, wr_data_acc;
  logic rd_data_q, rd_data_d, rd_stat_q, rd_stat_d, wr_data_q, wr_data_d;
  logic wr_start, pop, stat_end;

  assign hit_data    = (addr == DATA_ADDR);
  assign hit_stat    = (addr == STATUS_ADDR);
  assign rd_data_acc = ~mreq_n & ~rd_n & hit_data;
  assign rd_stat_acc = ~mreq_n & ~rd_n & hit_stat;
  assign wr_data_acc = ~mreq_n & ~wr_n & hit_data;
  assign sel         = rd_data_acc | rd_stat_acc;

  assign rd_data_d = rd_data_acc;
  assign rd_stat_d = rd_stat_acc;
  assign wr_data_d = wr_data_acc;

  assign wr_start = wr_data_acc & ~wr_data_q;
  assign stat_end = rd_stat_q & ~rd_stat_acc;

  // ---------------------------------------------------------------- TX engine
  logic [7:0]    hold_q, hold_d, tx_shift_q, tx_shift_d;
  logic          hold_full_q, hold_full_d, tx_q, tx_d;
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          tx_bit_end, tx_take, tx_drop_ev;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign tx         = tx_q;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_take     = 1'b0;
    tx_drop_ev  = 1'b0;

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end

    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) tx_take = 1'b1;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          // A pending byte starts immediately: no idle bit between frames.
          if (hold_full_q) begin
            tx_take = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_take) begin
      tx_shift_d  = hold_q;
      hold_full_d = 1'b0;
      tx_state_d  = TX_START;
      tx_cnt_d    = '0;
      tx_d        = 1'b0;
    end

    // Holding state is judged on the registered flag, so a write that lands
    // while the shifter is just taking the byte is still dropped.
    if (wr_start) begin
      if (hold_full_q) begin
        tx_drop_ev = 1'b1;
      end else begin
        hold_d      = din;
        hold_full_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX engine
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d, rx_line;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_bit_end, push, frm_ev;

  assign rx_line    = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], rx};
    rx_prev_d  = rx_line;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    frm_ev     = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_line) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == MID_LAST) begin
          rx_cnt_d = '0;
          if (rx_line) begin
            rx_state_d = RX_IDLE;  // false start
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          if (rx_line) begin
            push       = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frm_ev     = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_line) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic          fifo_empty, fifo_full, push_ok, ovr_ev;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  // Pop on the trailing edge of a data read so dout holds for the whole access.
  assign pop        = rd_data_q & ~rd_data_acc & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign push_ok    = push & (~fifo_full | pop);
  assign ovr_ev     = push & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------------------------------------------------------- sticky flags
  logic rx_ovr_q, rx_ovr_d, tx_drop_q, tx_drop_d, frm_err_q, frm_err_d;

  // Clearing at the end of a status read yields to an event in the same cycle.
  assign rx_ovr_d  = (rx_ovr_q  & ~stat_end) | ovr_ev;
  assign tx_drop_d = (tx_drop_q & ~stat_end) | tx_drop_ev;
  assign frm_err_d = (frm_err_q & ~stat_end) | frm_ev;

  // ---------------------------------------------------------------- read data
  always_comb begin
    dout = 8'h00;
    if (hit_data) begin
      dout = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    end else if (hit_stat) begin
      dout = {3'b000, frm_err_q, tx_drop_q, rx_ovr_q, ~fifo_empty, hold_full_q};
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q   <= 1'b0;
      rd_stat_q   <= 1'b0;
      wr_data_q   <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_q        <= 1'b1;
      rx_sync_q   <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      rx_ovr_q    <= 1'b0;
      tx_drop_q   <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_stat_q   <= rd_stat_d;
      wr_data_q   <= wr_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_drop_q   <= tx_drop_d;
      frm_err_q   <= frm_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z80_mmio_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_mmio_uart
// Purpose  : Self-checking bench for z80_mmio_uart at DIV = 16. A line
//            monitor decodes tx frames; a queue model tracks the RX FIFO
//            and the sticky status bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_mmio_uart;

  localparam int          DIV    = 16;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] DATA_A = 16'hFFFF;
  localparam logic [15:0] STAT_A = 16'hFFFD;

  logic        clk = 1'b0;
  logic        reset, mreq_n, rd_n, wr_n, rx, sel, tx;
  logic [15:0] addr;
  logic [7:0]  din, dout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  z80_mmio_uart #(
    .CLK_HZ(16), .BAUD(1), .DATA_ADDR(DATA_A), .STATUS_ADDR(STAT_A), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .mreq_n(mreq_n), .rd_n(rd_n),
    .wr_n(wr_n), .din(din), .dout(dout), .sel(sel), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ------------------------------------------------------------ tx monitor
  logic [7:0] mon_byte[$];
  int         mon_start[$];
  bit         mon_ok[$];

  initial begin : line_monitor
    int         c;
    int         st;
    logic [9:0] lv;
    bit         ok;
    c = -1; st = 0; lv = '0; ok = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        c = -1;
      end else if (c < 0) begin
        if (tx === 1'b0) begin
          c = 1; lv = '0; ok = 1'b1; st = cyc;
        end
      end else begin
        if (c % DIV == 0) lv[c / DIV] = tx;
        else if (tx !== lv[c / DIV]) ok = 1'b0;
        c = c + 1;
        if (c == 10 * DIV) begin
          if (lv[0] !== 1'b0 || lv[9] !== 1'b1) ok = 1'b0;
          mon_byte.push_back(lv[8:1]);
          mon_start.push_back(st);
          mon_ok.push_back(ok);
          c = -1;
        end
      end
    end
  end

  // ------------------------------------------------------------ reference model
  logic [7:0] m_fifo[$];
  bit m_ovr, m_drop, m_frm;

  function automatic void m_reset();
    m_fifo.delete();
    m_ovr = 0; m_drop = 0; m_frm = 0;
  endfunction

  function automatic void m_rx_frame(input logic [7:0] b, input logic stop);
    if (!stop)                     m_frm = 1;
    else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
    else                           m_ovr = 1;
  endfunction

  // Status value seen by a read, then the stickies clear as the read ends.
  function automatic logic [7:0] m_status_read(input logic txf);
    logic [7:0] s;
    s = {3'b000, m_frm, m_drop, m_ovr, (m_fifo.size() != 0), txf};
    m_frm = 0; m_drop = 0; m_ovr = 0;
    return s;
  endfunction

  function automatic logic [7:0] m_data_read();
    if (m_fifo.size() == 0) return 8'h00;
    return m_fifo.pop_front();
  endfunction

  // ------------------------------------------------------------ bus / line drivers
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    addr = a; din = d; mreq_n = 1'b0; wr_n = 1'b0;
    tick(hold);
    mreq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a, input int hold,
                          output logic [7:0] d, output logic s);
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    #2; d = dout; s = sel;
    tick(hold);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick(1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(DIV); end
    rx = stop; tick(DIV);
    rx = 1'b1; tick(4);
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = (n + 1) * 11 * DIV;
    while (mon_byte.size() < n && budget > 0) begin tick(1); budget--; end
    if (mon_byte.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_frames: got %0d frames, required %0d", mon_byte.size(), n);
    end
    tick(3 * DIV);
  endtask

  function automatic void clear_mon();
    mon_byte.delete(); mon_start.delete(); mon_ok.delete();
  endfunction

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    logic [7:0] d; logic s;
    reset = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rx = 1'b1;
    addr = 16'h0000; din = 8'h00;
    m_reset();
    tick(3);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b required 0", sel); end
    reset = 1'b0;
    tick(2);
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== 8'h00 || s !== 1'b1) begin errors++; $display("FAIL reset_status: got %02h sel %b required 00 sel 1", d, s); end
    cpu_read(DATA_A, 1, d, s);
    checks++; if (d !== 8'h00 || s !== 1'b1) begin errors++; $display("FAIL reset_data: got %02h sel %b required 00 sel 1", d, s); end
    cpu_read(16'h1234, 1, d, s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL miss_sel: got %b required 0", s); end
  endtask

  task automatic test_tx_single();
    logic [7:0] d; logic s; int k;
    clear_mon();
    k = cyc;
    cpu_write(DATA_A, 8'h55, 3);
    wait_frames(1);
    checks++; if (mon_byte.size() != 1) begin errors++; $display("FAIL tx_single_count: got %0d required 1", mon_byte.size()); end
    if (mon_byte.size() >= 1) begin
      checks++; if (mon_byte[0] !== 8'h55 || !mon_ok[0]) begin errors++; $display("FAIL tx_single_frame: got %02h ok %0d required 55 ok 1", mon_byte[0], mon_ok[0]); end
      checks++; if (mon_start[0] != k + 2) begin errors++; $display("FAIL tx_latency: got start %0d required %0d", mon_start[0], k + 2); end
    end
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL tx_single_status: got %02h required 00", d); end
  endtask

  task automatic test_tx_full();
    logic [7:0] d, b; logic s;
    clear_mon();
    b = 8'($urandom);
    cpu_write(DATA_A, b, 1);
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b1)) begin errors++; $display("FAIL tx_full_set: got %02h required 01", d); end
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL tx_full_clear: got %02h required 00", d); end
    wait_frames(1);
    checks++; if (mon_byte.size() != 1 || mon_byte[0] !== b) begin errors++; $display("FAIL tx_full_frame: got %0d frames first %02h required 1 frame %02h", mon_byte.size(), mon_byte[0], b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic s;
    clear_mon();
    cpu_write(DATA_A, 8'hA5, 1);
    tick(20);
    cpu_write(DATA_A, 8'h3C, 1);
    tick(20);
    cpu_write(DATA_A, 8'h77, 1);
    m_drop = 1;  // holding still owns 3C, so 77 is refused
    tick(1);
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b1)) begin errors++; $display("FAIL drop_status: got %02h required 09", d); end
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b1)) begin errors++; $display("FAIL drop_clear: got %02h required 01", d); end
    wait_frames(2);
    checks++; if (mon_byte.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d required 2", mon_byte.size()); end
    if (mon_byte.size() == 2) begin
      checks++; if (mon_byte[0] !== 8'hA5 || mon_byte[1] !== 8'h3C || !mon_ok[0] || !mon_ok[1]) begin
        errors++; $display("FAIL b2b_bytes: got %02h %02h required a5 3c", mon_byte[0], mon_byte[1]); end
      checks++; if (mon_start[1] - mon_start[0] != 10 * DIV) begin
        errors++; $display("FAIL b2b_gap: got spacing %0d required %0d", mon_start[1] - mon_start[0], 10 * DIV); end
    end
  endtask

  task automatic test_tx_random();
    logic [7:0] d, b; logic s; int budget;
    logic [7:0] exp_q[$];
    clear_mon();
    for (int n = 0; n < 5; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      cpu_write(DATA_A, b, $urandom_range(1, 4));
      tick($urandom_range(0, 3));
      budget = 12 * DIV;
      d = 8'hFF;
      while (budget > 0) begin
        cpu_read(STAT_A, 1, d, s);
        if (d[0] === 1'b0) break;
        budget--;
      end
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL tx_poll: got %02h required 00", d); end
    end
    wait_frames(5);
    checks++; if (mon_byte.size() != 5) begin errors++; $display("FAIL tx_rand_count: got %0d required 5", mon_byte.size()); end
    for (int i = 0; i < 5 && i < mon_byte.size(); i++) begin
      checks++; if (mon_byte[i] !== exp_q[i] || !mon_ok[i]) begin
        errors++; $display("FAIL tx_rand_byte%0d: got %02h ok %0d required %02h", i, mon_byte[i], mon_ok[i], exp_q[i]); end
    end
  endtask

  task automatic test_rx_single();
    logic [7:0] d; logic s;
    send_rx(8'hC3, 1'b1); m_rx_frame(8'hC3, 1'b1);
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL rx_status: got %02h required 02", d); end
    cpu_read(DATA_A, 2, d, s);
    checks++; if (d !== m_data_read() || s !== 1'b1) begin errors++; $display("FAIL rx_data: got %02h required c3", d); end
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL rx_status_empty: got %02h required 00", d); end
    cpu_read(DATA_A, 1, d, s);
    checks++; if (d !== m_data_read()) begin errors++; $display("FAIL rx_empty_read: got %02h required 00", d); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] d, b, e; logic s;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1); m_rx_frame(b, 1'b1);
    end
    cpu_read(STAT_A, 1, d, s);
    e = m_status_read(1'b0);
    checks++; if (d !== e) begin errors++; $display("FAIL ovr_status: got %02h required %02h", d, e); end
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(DATA_A, 1, d, s);
      e = m_data_read();
      checks++; if (d !== e) begin errors++; $display("FAIL ovr_drain%0d: got %02h required %02h", i, d, e); end
    end
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL ovr_after: got %02h required 00", d); end
  endtask

  task automatic test_rx_random();
    logic [7:0] d, b, e; logic s; int nr;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1); m_rx_frame(b, 1'b1);
      nr = $urandom_range(0, 2);
      for (int r = 0; r < nr; r++) begin
        cpu_read(DATA_A, $urandom_range(1, 3), d, s);
        e = m_data_read();
        checks++; if (d !== e) begin errors++; $display("FAIL rx_rand_read: got %02h required %02h", d, e); end
      end
    end
    cpu_read(STAT_A, 1, d, s);
    e = m_status_read(1'b0);
    checks++; if (d !== e) begin errors++; $display("FAIL rx_rand_status: got %02h required %02h", d, e); end
    for (int r = 0; r < DEPTH + 1; r++) begin
      cpu_read(DATA_A, 1, d, s);
      e = m_data_read();
      checks++; if (d !== e) begin errors++; $display("FAIL rx_rand_drain: got %02h required %02h", d, e); end
    end
  endtask

  task automatic test_rx_errors();
    logic [7:0] d, e; logic s;
    send_rx(8'($urandom), 1'b0); m_rx_frame(8'h00, 1'b0);
    cpu_read(STAT_A, 1, d, s);
    e = m_status_read(1'b0);
    checks++; if (d !== e) begin errors++; $display("FAIL frm_status: got %02h required %02h", d, e); end
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL frm_clear: got %02h required 00", d); end
    rx = 1'b0; tick(4); rx = 1'b1; tick(12 * DIV);
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL glitch_status: got %02h required 00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic s;
    clear_mon();
    cpu_write(DATA_A, 8'h00, 1);
    tick(30);
    rx = 1'b0; tick(20);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: got %b required 0", tx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b required 1", tx); end
    m_reset();
    tick(2);
    rx = 1'b1;
    reset = 1'b0;
    tick(3);
    cpu_read(STAT_A, 1, d, s);
    checks++; if (d !== m_status_read(1'b0)) begin errors++; $display("FAIL post_reset_status: got %02h required 00", d); end
    cpu_read(DATA_A, 1, d, s);
    checks++; if (d !== m_data_read()) begin errors++; $display("FAIL post_reset_data: got %02h required 00", d); end
    tick(12 * DIV);
    checks++; if (mon_byte.size() != 0) begin errors++; $display("FAIL post_reset_frames: got %0d required 0", mon_byte.size()); end
    cpu_write(DATA_A, 8'h81, 1);
    wait_frames(1);
    checks++; if (mon_byte.size() != 1 || mon_byte[0] !== 8'h81 || !mon_ok[0]) begin
      errors++; $display("FAIL post_reset_tx: got %0d frames first %02h required 1 frame 81", mon_byte.size(), mon_byte[0]); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_full();
    test_back_to_back();
    test_tx_random();
    test_rx_single();
    test_rx_overflow();
    test_rx_random();
    test_rx_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
